crc32_frame_serializer: RTL and testbench

- Upstream feeder for the serial CRC-32 encoder (crc32_serial).
- Accepts byte-wide frames over a valid/ready stream with an end-of-frame flag, and converts them to a single-bit stream, MSB first.
- Generates the encoder's control strobes: a start strobe aligned with the first bit and a finish strobe after the last bit.
- Enforces a maximum frame length and flags overruns.

---
 rtl/crc32_pkg.sv | 14 +
 rtl/crc32_frame_serializer.sv | 136 +++++++++++++
 tb/tb_crc32_frame_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc32_pkg.sv
// Shared types and constants for the serial CRC-32 path: serializer, encoder and their benches.
package crc32_pkg;

  localparam int BYTE_W = 8;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/crc32_frame_serializer.sv
// Byte-stream to bit-stream feeder for the serial CRC-32 encoder, MSB first,
// with load/finish strobes and a maximum-frame-length guard.
//
// state  | meaning
// IDLE   | no frame in progress, ready for byte 0
// SHIFT  | emitting one bit per cycle; may take the next byte on bit 0
// WAIT   | mid-frame, upstream starved; bit_valid low
// FINISH | one-cycle finish strobe, frame_len updated
module crc32_frame_serializer
  import crc32_pkg::*;
#(
  parameter int MAX_BYTES = 256,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_load,
  output logic              bit_finish,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_len,
  output logic              err_len
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BYTE_W-1:0]  r_shreg;
  logic [2:0]         r_bit_cnt;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [CNT_W-1:0]   r_frame_len;
  logic               r_last_q;
  logic               r_first_q;
  logic               r_err_len;

  logic               w_accept;
  logic               w_last_bit;
  logic               w_limit;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_accept   = s_valid & s_ready;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_cnt_nxt  = (r_state == IDLE) ? CNT_W'(1) : r_byte_cnt + CNT_W'(1);
  // The byte that reaches the limit closes the frame even without s_last.
  assign w_limit    = !s_last && (w_cnt_nxt == CNT_W'(MAX_BYTES));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_last_bit) begin
          if (r_last_q)       w_state_nxt = FINISH;
          else if (!w_accept) w_state_nxt = WAIT;
        end
      end
      WAIT:    if (w_accept) w_state_nxt = SHIFT;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    bit_load   = 1'b0;
    bit_finish = 1'b0;
    busy       = 1'b1;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = s_valid;
      end
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = r_shreg[BYTE_W-1];
        bit_load  = r_first_q;
        s_ready   = w_last_bit & ~r_last_q;
      end
      WAIT: begin
        s_ready = 1'b1;
        bit_out = r_shreg[BYTE_W-1];
      end
      FINISH:  bit_finish = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Shift register is not advanced on bit 0 so bit_out holds through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_frame_len <= '0;
      r_last_q    <= 1'b0;
      r_first_q   <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_first_q <= 1'b0;
      if (w_accept) begin
        r_shreg    <= s_data;
        r_bit_cnt  <= '0;
        r_byte_cnt <= w_cnt_nxt;
        r_last_q   <= s_last | w_limit;
        if (r_state == IDLE) begin
          r_first_q <= 1'b1;
          r_err_len <= w_limit;
        end else if (w_limit) begin
          r_err_len <= 1'b1;
        end
      end else if (r_state == SHIFT) begin
        if (!w_last_bit) begin
          r_shreg   <= r_shreg << 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end else if (r_last_q) begin
          r_frame_len <= r_byte_cnt;
        end
      end
    end
  end

  assign frame_len = r_frame_len;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_crc32_frame_serializer.sv
// Directed bench for crc32_frame_serializer: a default-size instance and a MAX_BYTES=4 instance.
module tb_crc32_frame_serializer;
  import crc32_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d_data;
  logic       d_valid, d_last, sel4;
  logic       s_valid, s4_valid;

  logic       s_ready, bit_out, bit_valid, bit_load, bit_finish, busy, err_len;
  logic [8:0] frame_len;
  logic       s_ready_4, bit_out_4, bit_valid_4, bit_load_4, bit_finish_4, busy_4, err_len_4;
  logic [2:0] frame_len_4;

  assign s_valid  = d_valid & ~sel4;
  assign s4_valid = d_valid & sel4;

  crc32_frame_serializer dut (
    .clk(clk), .rst(rst), .s_data(d_data), .s_valid(s_valid), .s_last(d_last),
    .s_ready(s_ready), .bit_out(bit_out), .bit_valid(bit_valid), .bit_load(bit_load),
    .bit_finish(bit_finish), .busy(busy), .frame_len(frame_len), .err_len(err_len)
  );

  crc32_frame_serializer #(.MAX_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .s_data(d_data), .s_valid(s4_valid), .s_last(d_last),
    .s_ready(s_ready_4), .bit_out(bit_out_4), .bit_valid(bit_valid_4), .bit_load(bit_load_4),
    .bit_finish(bit_finish_4), .busy(busy_4), .frame_len(frame_len_4), .err_len(err_len_4)
  );

  logic       w_rdy, w_bo, w_bv, w_bl, w_bf, w_busy, w_err;
  logic [8:0] w_flen;
  assign w_rdy  = sel4 ? s_ready_4    : s_ready;
  assign w_bo   = sel4 ? bit_out_4    : bit_out;
  assign w_bv   = sel4 ? bit_valid_4  : bit_valid;
  assign w_bl   = sel4 ? bit_load_4   : bit_load;
  assign w_bf   = sel4 ? bit_finish_4 : bit_finish;
  assign w_busy = sel4 ? busy_4       : busy;
  assign w_err  = sel4 ? err_len_4    : err_len;
  assign w_flen = sel4 ? {6'd0, frame_len_4} : frame_len;

  int tests = 0;
  int fails = 0;

  logic [7:0] stim_data [16];
  logic       stim_last [16];
  int         stim_gap  [16];
  int         stim_n;

  logic       rec_rdy [128];
  logic       rec_bo  [128];
  logic       rec_bv  [128];
  logic       rec_bl  [128];
  logic       rec_bf  [128];
  logic       rec_busy[128];
  logic       rec_err [128];
  logic [8:0] rec_flen[128];

  // Presents stim bytes on the stream; stim_gap[i] withholds byte i for that many ready cycles.
  // Cycle c is the period from negedge c to the following posedge.
  task automatic run_frame(input int n_cyc, input bit use4, input int rst_at);
    int idx;
    int gap;
    sel4 = use4;
    idx  = 0;
    gap  = stim_gap[0];
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      rst = (c == rst_at);
      if (rst) idx = stim_n;
      if (idx < stim_n && gap == 0) begin
        d_valid = 1'b1; d_data = stim_data[idx]; d_last = stim_last[idx];
      end else begin
        d_valid = 1'b0; d_data = 8'hEE; d_last = 1'b1;
      end
      #1;
      rec_rdy[c] = w_rdy;  rec_bo[c] = w_bo;  rec_bv[c] = w_bv;  rec_bl[c] = w_bl;
      rec_bf[c]  = w_bf;   rec_busy[c] = w_busy; rec_err[c] = w_err; rec_flen[c] = w_flen;
      if (d_valid && w_rdy) begin
        idx++;
        if (idx < stim_n) gap = stim_gap[idx];
      end else if (w_rdy && gap > 0) begin
        gap--;
      end
    end
    @(negedge clk);
    d_valid = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    sel4 = 1'b0; d_valid = 1'b0; d_data = 8'h00; d_last = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({s_ready, bit_valid, bit_out, bit_load, bit_finish, busy, err_len} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_main got %b expected 1000000", {s_ready, bit_valid, bit_out, bit_load, bit_finish, busy, err_len});
    end
    tests++;
    if (frame_len !== 9'd0) begin fails++; $display("FAIL reset_frame_len got %0d expected 0", frame_len); end
    tests++;
    if ({s_ready_4, bit_valid_4, bit_out_4, bit_load_4, bit_finish_4, busy_4, err_len_4, frame_len_4} !== 10'b1000000000) begin
      fails++;
      $display("FAIL reset_max4 got %b expected 1000000000", {s_ready_4, bit_valid_4, bit_out_4, bit_load_4, bit_finish_4, busy_4, err_len_4, frame_len_4});
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] pat;
    logic [3:0] exp_v;
    pat = 8'hA5;
    stim_n = 1; stim_data[0] = pat; stim_last[0] = 1'b1; stim_gap[0] = 0;
    run_frame(12, 1'b0, -1);
    tests++;
    if ({rec_rdy[0], rec_busy[0]} !== 2'b11) begin fails++; $display("FAIL single_accept got %b expected 11", {rec_rdy[0], rec_busy[0]}); end
    for (int c = 1; c <= 10; c++) begin
      exp_v = {(c <= 8), (c <= 8) ? pat[8-c] : 1'b0, (c == 1), (c == 9)};
      tests++;
      if ({rec_bv[c], rec_bv[c] & rec_bo[c], rec_bl[c], rec_bf[c]} !== exp_v) begin
        fails++;
        $display("FAIL single_bits c=%0d got %b expected %b", c, {rec_bv[c], rec_bv[c] & rec_bo[c], rec_bl[c], rec_bf[c]}, exp_v);
      end
    end
    tests++;
    if (rec_flen[9] !== 9'd1) begin fails++; $display("FAIL single_frame_len got %0d expected 1", rec_flen[9]); end
    tests++;
    if (rec_busy[10] !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b expected 0", rec_busy[10]); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] st;
    logic [3:0]  exp_v;
    st = 24'hFF0081;
    stim_n = 3;
    stim_data[0] = 8'hFF; stim_data[1] = 8'h00; stim_data[2] = 8'h81;
    stim_last[0] = 1'b0;  stim_last[1] = 1'b0;  stim_last[2] = 1'b1;
    stim_gap[0] = 0; stim_gap[1] = 0; stim_gap[2] = 0;
    run_frame(28, 1'b0, -1);
    for (int c = 0; c <= 25; c++) begin
      tests++;
      if (rec_rdy[c] !== (c == 0 || c == 8 || c == 16)) begin
        fails++; $display("FAIL b2b_ready c=%0d got %b", c, rec_rdy[c]);
      end
    end
    for (int c = 1; c <= 25; c++) begin
      exp_v = {(c <= 24), (c <= 24) ? st[24-c] : 1'b0, (c == 1), (c == 25)};
      tests++;
      if ({rec_bv[c], rec_bv[c] & rec_bo[c], rec_bl[c], rec_bf[c]} !== exp_v) begin
        fails++;
        $display("FAIL b2b_bits c=%0d got %b expected %b", c, {rec_bv[c], rec_bv[c] & rec_bo[c], rec_bl[c], rec_bf[c]}, exp_v);
      end
    end
    tests++;
    if (rec_flen[25] !== 9'd3) begin fails++; $display("FAIL b2b_frame_len got %0d expected 3", rec_flen[25]); end
    tests++;
    if ({rec_busy[25], rec_busy[26]} !== 2'b10) begin fails++; $display("FAIL b2b_busy got %b expected 10", {rec_busy[25], rec_busy[26]}); end
  endtask

  task automatic test_stall();
    logic [15:0] bits;
    int nbits;
    int nload;
    stim_n = 2;
    stim_data[0] = 8'hC3; stim_data[1] = 8'h5A;
    stim_last[0] = 1'b0;  stim_last[1] = 1'b1;
    stim_gap[0] = 0; stim_gap[1] = 5;
    run_frame(26, 1'b0, -1);
    bits = '0; nbits = 0; nload = 0;
    for (int c = 1; c <= 22; c++) begin
      tests++;
      if (rec_bv[c] !== ((c <= 8) || (c >= 14 && c <= 21))) begin
        fails++; $display("FAIL stall_valid c=%0d got %b", c, rec_bv[c]);
      end
    end
    for (int c = 0; c < 26; c++) begin
      if (rec_bv[c] === 1'b1) begin bits = {bits[14:0], rec_bo[c]}; nbits++; end
      if (rec_bl[c] === 1'b1) nload++;
    end
    tests++;
    if (bits !== 16'hC35A || nbits != 16) begin fails++; $display("FAIL stall_stream got %h/%0d expected c35a/16", bits, nbits); end
    tests++;
    if (nload != 1 || rec_bl[1] !== 1'b1) begin fails++; $display("FAIL stall_load got %0d strobes expected 1", nload); end
    tests++;
    if ({rec_bf[21], rec_bf[22]} !== 2'b01 || rec_flen[22] !== 9'd2) begin
      fails++; $display("FAIL stall_finish got %b len %0d expected 01 len 2", {rec_bf[21], rec_bf[22]}, rec_flen[22]);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] st1;
    logic [15:0] st2;
    st1 = 32'h11223344;
    st2 = 16'h5566;
    stim_n = 6;
    for (int i = 0; i < 6; i++) begin
      stim_data[i] = 8'((i + 1) * 8'h11);
      stim_last[i] = (i == 5);
      stim_gap[i]  = 0;
    end
    run_frame(54, 1'b1, -1);
    for (int c = 1; c <= 32; c++) begin
      tests++;
      if ({rec_bv[c], rec_bo[c]} !== {1'b1, st1[32-c]}) begin
        fails++; $display("FAIL overrun_bits1 c=%0d got %b expected %b", c, {rec_bv[c], rec_bo[c]}, {1'b1, st1[32-c]});
      end
    end
    for (int c = 35; c <= 50; c++) begin
      tests++;
      if ({rec_bv[c], rec_bo[c]} !== {1'b1, st2[50-c]}) begin
        fails++; $display("FAIL overrun_bits2 c=%0d got %b expected %b", c, {rec_bv[c], rec_bo[c]}, {1'b1, st2[50-c]});
      end
    end
    tests++;
    if ({rec_err[24], rec_err[25]} !== 2'b01) begin fails++; $display("FAIL overrun_err_set got %b expected 01", {rec_err[24], rec_err[25]}); end
    tests++;
    if (rec_rdy[32] !== 1'b0) begin fails++; $display("FAIL overrun_no_reload got %b expected 0", rec_rdy[32]); end
    tests++;
    if ({rec_bf[33], rec_err[33], rec_flen[33]} !== {1'b1, 1'b1, 9'd4}) begin
      fails++; $display("FAIL overrun_finish1 got bf=%b err=%b len=%0d expected 1 1 4", rec_bf[33], rec_err[33], rec_flen[33]);
    end
    tests++;
    if ({rec_err[34], rec_bl[35], rec_err[35]} !== 3'b110) begin
      fails++; $display("FAIL overrun_err_clear got %b expected 110", {rec_err[34], rec_bl[35], rec_err[35]});
    end
    tests++;
    if ({rec_bf[51], rec_err[51], rec_flen[51]} !== {1'b1, 1'b0, 9'd2}) begin
      fails++; $display("FAIL overrun_finish2 got bf=%b err=%b len=%0d expected 1 0 2", rec_bf[51], rec_err[51], rec_flen[51]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nfin;
    logic [7:0] pat;
    logic [3:0] exp_v;
    stim_n = 3;
    stim_data[0] = 8'hAA; stim_data[1] = 8'hBB; stim_data[2] = 8'hCC;
    stim_last[0] = 1'b0;  stim_last[1] = 1'b0;  stim_last[2] = 1'b1;
    stim_gap[0] = 0; stim_gap[1] = 0; stim_gap[2] = 0;
    run_frame(20, 1'b0, 13);
    tests++;
    if ({rec_bv[13], rec_bo[13]} !== 2'b11) begin fails++; $display("FAIL midrst_bit3 got %b expected 11", {rec_bv[13], rec_bo[13]}); end
    tests++;
    if ({rec_rdy[14], rec_bv[14], rec_bf[14], rec_busy[14], rec_err[14]} !== 5'b10000 || rec_flen[14] !== 9'd0) begin
      fails++; $display("FAIL midrst_after got %b len %0d expected 10000 len 0", {rec_rdy[14], rec_bv[14], rec_bf[14], rec_busy[14], rec_err[14]}, rec_flen[14]);
    end
    nfin = 0;
    for (int c = 13; c < 20; c++) if (rec_bf[c] !== 1'b0) nfin++;
    tests++;
    if (nfin != 0) begin fails++; $display("FAIL midrst_no_finish got %0d strobes expected 0", nfin); end

    pat = 8'h3C;
    stim_n = 1; stim_data[0] = pat; stim_last[0] = 1'b1; stim_gap[0] = 0;
    run_frame(12, 1'b0, -1);
    for (int c = 1; c <= 9; c++) begin
      exp_v = {(c <= 8), (c <= 8) ? pat[8-c] : 1'b0, (c == 1), (c == 9)};
      tests++;
      if ({rec_bv[c], rec_bv[c] & rec_bo[c], rec_bl[c], rec_bf[c]} !== exp_v) begin
        fails++;
        $display("FAIL midrst_fresh c=%0d got %b expected %b", c, {rec_bv[c], rec_bv[c] & rec_bo[c], rec_bl[c], rec_bf[c]}, exp_v);
      end
    end
    tests++;
    if (rec_flen[9] !== 9'd1) begin fails++; $display("FAIL midrst_fresh_len got %0d expected 1", rec_flen[9]); end
  endtask

  // Reference encoder: reflected-input CRC-32, init and final xor all ones, fed from the observed bits.
  task automatic test_crc_e2e();
    logic [31:0] crc;
    logic [31:0] crc_r;
    logic [7:0]  b;
    logic        fb;
    int nbits;
    int nload;
    stim_n = 9;
    for (int i = 0; i < 9; i++) begin
      stim_data[i] = 8'h31 + 8'(i);
      stim_last[i] = (i == 8);
      stim_gap[i]  = 0;
    end
    run_frame(78, 1'b0, -1);
    crc = 32'hFFFF_FFFF; b = '0; nbits = 0; nload = 0;
    for (int c = 0; c < 78; c++) begin
      if (rec_bl[c] === 1'b1) nload++;
      if (rec_bv[c] === 1'b1) begin
        b = {b[6:0], rec_bo[c]};
        nbits++;
        if (nbits % 8 == 0) begin
          for (int k = 0; k < 8; k++) begin
            fb  = crc[31] ^ b[k];
            crc = {crc[30:0], 1'b0};
            if (fb) crc = crc ^ CRC32_POLY;
          end
        end
      end
    end
    for (int i = 0; i < 32; i++) crc_r[i] = crc[31-i];
    crc_r = ~crc_r;
    tests++;
    if (crc_r !== 32'hCBF43926) begin fails++; $display("FAIL e2e_crc got %h expected cbf43926", crc_r); end
    tests++;
    if (nbits != 72 || nload != 1) begin fails++; $display("FAIL e2e_counts got bits=%0d loads=%0d expected 72 1", nbits, nload); end
    tests++;
    if ({rec_bv[72], rec_bf[72], rec_bf[73]} !== 3'b101 || rec_flen[73] !== 9'd9) begin
      fails++; $display("FAIL e2e_finish got %b len %0d expected 101 len 9", {rec_bv[72], rec_bf[72], rec_bf[73]}, rec_flen[73]);
    end
  endtask

  initial begin
    sel4 = 1'b0; d_valid = 1'b0; d_data = 8'h00; d_last = 1'b0; rst = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_reset_mid_frame();
    test_crc_e2e();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
